// File: rtl/seg_capture.sv
// Receive side of the seven-segment display link: waits for each multiplexed digit's
// active-low pattern to hold steady, decodes it back to hex and assembles the display word.
module seg_capture #(
  parameter int NDIGITS = 4,
  parameter int STABLE  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [6:0]             seg,
  input  logic [NDIGITS-1:0]     dig_en,
  output logic [4*NDIGITS-1:0]   value,
  output logic [NDIGITS-1:0]     digit_valid,
  output logic                   err,
  output logic                   update
);

  localparam int CW = $clog2(STABLE + 1);
  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [6:0]           s_seg;
  logic [NDIGITS-1:0]   s_en;

  logic                 onehot;
  logic                 same;
  logic [IW-1:0]        idx;
  logic [4:0]           dec;     // {legal, nibble}
  logic [3:0]           old_nib;

  // Inverse of the board encoder; anything else is not a hex glyph.
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h40:   decode = 5'h10;
      7'h79:   decode = 5'h11;
      7'h24:   decode = 5'h12;
      7'h30:   decode = 5'h13;
      7'h19:   decode = 5'h14;
      7'h12:   decode = 5'h15;
      7'h02:   decode = 5'h16;
      7'h78:   decode = 5'h17;
      7'h00:   decode = 5'h18;
      7'h10:   decode = 5'h19;
      7'h08:   decode = 5'h1A;
      7'h03:   decode = 5'h1B;
      7'h46:   decode = 5'h1C;
      7'h21:   decode = 5'h1D;
      7'h06:   decode = 5'h1E;
      7'h0E:   decode = 5'h1F;
      default: decode = 5'h00;
    endcase
  endfunction

  // The run length is judged on the sample entering the input register this edge, compared
  // with the one already held, so the commit lands on the edge that registers the STABLE-th sample.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    onehot  = ($countones(~dig_en) == 1);
    same    = (seg == s_seg) && (dig_en == s_en);
    idx     = '0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (!dig_en[i]) idx = IW'(i);
    end
    dec     = decode(seg);
    old_nib = value[{idx, 2'b00} +: 4];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees
  // the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      s_seg       <= 7'h7F;
      s_en        <= '1;
      value       <= '0;
      digit_valid <= '0;
      err         <= 1'b0;
      update      <= 1'b0;
    end else begin
      s_seg  <= seg;
      s_en   <= dig_en;
      update <= 1'b0;
      if (!onehot) begin
        state <= IDLE;
        cnt   <= '0;
      end else if (!same || state == IDLE) begin
        state <= COUNT;
        cnt   <= CW'(1);
      end else if (state == COUNT) begin
        if (cnt < CW'(STABLE)) cnt <= cnt + 1'b1;
        if (cnt == CW'(STABLE - 1)) begin
          state <= DONE;
          if (dec[4]) begin
            value[{idx, 2'b00} +: 4] <= dec[3:0];
            digit_valid[idx]         <= 1'b1;
            if (old_nib != dec[3:0] || !digit_valid[idx]) update <= 1'b1;
          end else begin
            digit_valid[idx] <= 1'b0;
            err              <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: doc/seg_capture.md
# seg_capture

Receive side of the seven-segment display interface. The block samples a time-multiplexed, active-low segment bus with its per-digit enables. It waits for each digit's pattern to be stable, then decodes the pattern back to a 4-bit hex value. The recovered digits are assembled into one word for loopback checking of the display path on the board.

## Interface
- NDIGITS, 4: number of multiplexed digits; one 4-bit nibble each.
- STABLE, 4: consecutive identical samples required before commit; must be 2..255.

- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- seg  input  7  active-low segment pattern; bit0=a … bit6=g.
- dig_en  input  NDIGITS  active-low digit enables; exactly one low selects a digit.
- value  output  4*NDIGITS  recovered digits; digit i in value[4i+3:4i].
- digit_valid  output  NDIGITS  bit i set when digit i last committed a legal pattern.
- err  output  1  sticky flag: some committed pattern was illegal.
- update  output  1  one-cycle pulse when any value nibble changed on a commit.

## Operation
- Input stage:
  - seg and dig_en are registered every cycle into s_seg / s_en.
  - The previous sample is also held in p_seg / p_en.
- Decode table, inverse of the board encoder (pattern -> value):
  - 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7
  - 00->8, 10->9, 08->A, 03->B, 46->C, 21->D, 06->E, 0E->F
  - All other patterns are illegal.
- State machine:
  - IDLE: s_en not one-hot-low (all high = blank, or several low). Counter held at 0; no commit.
  - COUNT: s_en is one-hot-low.
    - Counter increments while (s_seg, s_en) equals (p_seg, p_en).
    - Any difference reloads the counter to 1 and stays in COUNT, or goes to IDLE if s_en is not one-hot.
    - When the counter reaches STABLE, commit and go to DONE.
  - DONE: the sample is unchanged; no further commits. Any change -> COUNT with counter 1, or IDLE.
- Commit for digit i, where i is the index of the low bit in s_en:
  - Legal pattern: write the nibble and set digit_valid[i]. update=1 for the cycle only if the new nibble differs from the old nibble or digit_valid[i] was 0.
  - Illegal pattern: clear digit_valid[i], keep the old nibble, set err.
- err clears only on reset.
- Counter width is clog2(STABLE+1) bits; it saturates and never wraps.

## Timing
- Reset values:
  - value=0, digit_valid=0, err=0, update=0.
  - s_seg/p_seg=7'h7F, s_en/p_en=all ones.
  - counter=0, state IDLE.
- Latency: seg/dig_en captured first at edge t0 and held constant gives outputs updated at edge t0+STABLE-1, i.e. the edge that makes STABLE identical samples. update is high in the following cycle only.
- value, digit_valid, err and update change only on the commit edge.
- update is a single-cycle pulse and is never asserted two cycles in a row for the same run.
- Input change on the commit edge itself: the commit uses the registered sample; the new sample starts a fresh run.
- reset asserted mid-run or in DONE: on the same edge, all state and outputs return to reset values and no commit occurs.
- Back-to-back digits (scan to the next digit with no blank cycle): treated as a sample change; each digit needs its own STABLE run.

## Test plan
- Reset: drive seg=7'h24 and dig_en=4'b1110, assert reset 3 cycles -> value=16'h0000, digit_valid=0000, err=0, update=0 throughout.
- Single digit, STABLE=4: dig_en=4'b1110, seg=7'h24 held 10 cycles -> value[3:0]=2, digit_valid=0001 after the 4th sample; exactly one update pulse; no second pulse.
- Glitch reject: digit 1, seg=7'h24 for 3 samples then 7'h30 held -> 2 is never committed; value[7:4]=3 four samples after the change; one update.
- Illegal pattern: digit 2 holds 5 (7'h12), then seg=7'h7F held 4 samples -> digit_valid[2]=0, value[11:8] stays 5, err=1. err is still 1 after legal patterns follow.
- Invalid select: dig_en=4'b1111, then 4'b1100, each held 20 cycles with seg=7'h00 -> no output change, no update.
- Scan loopback: cycle digits 0..3 for 8 cycles each with encoder outputs for E, D, 0, C -> value=16'hC0DE, digit_valid=1111. Repeat with all 16 hex codes through the encoder table -> each recovered exactly. Assert reset mid-run -> outputs return to 0 on that edge.
